// File: rtl/filt_sinc_sync.sv
// filt_sinc_sync -- fully synchronous sigma-delta decimation filter data unit.
//
// The modulator bit stream is sampled on clock-enable strobes generated in
// the SYSCLK domain (synchronised SDCLK edges or an internal divider).
// Strobes drive three integrators. Every OSR strobes a comb stage produces a
// sinc1/sinc2/sinc3/sincfast result, which is arithmetically shifted,
// saturated to OUT_W bits and offered on a valid/ack handshake.
//
// Ports
//   SYSCLK, SYSRSTn       only clock, async active-low reset
//   DSDIN, SDCLK          asynchronous modulator data / clock
//   reg_filtmode[1:0]     00 SDCLK rise, 01 SDCLK fall, 10 divider, 11 off
//   reg_filtdiv[3:0]      divider period = 4*div+4 cycles (mode 10)
//   reg_filtdec[DEC_W-1]  OSR-1
//   reg_filten            enable; low clears and holds the datapath
//   reg_filtst[1:0]       00 sincfast, 01 sinc1, 10 sinc2, 11 sinc3
//   reg_filtsh[4:0]       arithmetic right shift of the result
//   filt_data_ack         consumer took filt_data_out
//   filt_data_out         shifted, saturated result
//   filt_data_valid       result pending
//   filt_data_update      one-cycle pulse per new result
//   filt_overrun          sticky: result overwritten while unacknowledged
module filt_sinc_sync #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 32,
  parameter int DEC_W = 8
) (
  input  logic             SYSCLK,
  input  logic             SYSRSTn,
  input  logic             DSDIN,
  input  logic             SDCLK,
  input  logic [1:0]       reg_filtmode,
  input  logic [3:0]       reg_filtdiv,
  input  logic [DEC_W-1:0] reg_filtdec,
  input  logic             reg_filten,
  input  logic [1:0]       reg_filtst,
  input  logic [4:0]       reg_filtsh,
  input  logic             filt_data_ack,
  output logic [OUT_W-1:0] filt_data_out,
  output logic             filt_data_valid,
  output logic             filt_data_update,
  output logic             filt_overrun
);

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_DIV  = 2'b10;

  localparam logic [1:0] ST_FAST = 2'b00;
  localparam logic [1:0] ST_S1   = 2'b01;
  localparam logic [1:0] ST_S2   = 2'b10;

  localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // ---------------------------------------------------------------------
  // Synchronisers, edge detect, divider
  // ---------------------------------------------------------------------
  logic       dsd_s1_q, dsd_s2_q;
  logic       sdc_s1_q, sdc_s2_q, sdc_prev_q;
  logic [1:0] prime_q;
  logic [5:0] div_cnt_q;
  logic [5:0] div_lim;
  logic       div_wrap;
  logic       stb;

  assign div_lim  = {reg_filtdiv, 2'b11};
  // >= keeps the divider sane if reg_filtdiv shrinks below the count
  assign div_wrap = (div_cnt_q >= div_lim);

  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      dsd_s1_q   <= 1'b0;
      dsd_s2_q   <= 1'b0;
      sdc_s1_q   <= 1'b0;
      sdc_s2_q   <= 1'b0;
      sdc_prev_q <= 1'b0;
      prime_q    <= 2'd0;
      div_cnt_q  <= 6'd0;
    end else begin
      dsd_s1_q <= DSDIN;
      dsd_s2_q <= dsd_s1_q;
      sdc_s1_q <= SDCLK;
      sdc_s2_q <= sdc_s1_q;
      if (!reg_filten) begin
        sdc_prev_q <= 1'b0;
        prime_q    <= 2'd0;
      end else begin
        sdc_prev_q <= sdc_s2_q;
        if (prime_q != 2'd3) prime_q <= prime_q + 2'd1;
      end
      if (!reg_filten || reg_filtmode != MODE_DIV) div_cnt_q <= 6'd0;
      else if (div_wrap)                            div_cnt_q <= 6'd0;
      else                                          div_cnt_q <= div_cnt_q + 6'd1;
    end
  end

  // Edges are ignored until the chain has been refilled after reset or
  // enable, so the 0->1 seen while the flops reload is never a strobe.
  always_comb begin
    stb = 1'b0;
    if (reg_filten && prime_q == 2'd3) begin
      case (reg_filtmode)
        MODE_RISE: stb = sdc_s2_q & ~sdc_prev_q;
        MODE_FALL: stb = ~sdc_s2_q & sdc_prev_q;
        default:   stb = 1'b0;
      endcase
    end
    if (reg_filten && reg_filtmode == MODE_DIV) stb = div_wrap;
  end

  // ---------------------------------------------------------------------
  // Integrators, decimation, comb, shift/saturate, handshake
  // ---------------------------------------------------------------------
  logic signed [ACC_W-1:0] cn1_q, cn2_q, cn3_q, cn1_d, cn2_d, cn3_d;
  logic signed [ACC_W-1:0] xdl_q, c1dl_q, c2dl1_q, c2dl2_q;
  logic signed [ACC_W-1:0] xdl_d, c1dl_d, c2dl1_d, c2dl2_d;
  logic [DEC_W-1:0]        dec_cnt_q, dec_cnt_d;
  logic                    comb_stb_q, comb_stb_d;
  logic [2:0]              wu_cnt_q, wu_cnt_d, wu_need;
  logic [OUT_W-1:0]        dout_q, dout_d;
  logic                    valid_q, valid_d, upd_q, upd_d, ovr_q, ovr_d;

  logic signed [ACC_W-1:0] inc, x, c1, c2, c3, fast, res, shv;
  logic [OUT_W-1:0]        sat;
  logic                    dec_wrap, wu_done, accept;

  assign inc      = dsd_s2_q ? ACC_W'(1) : '1;
  // wrapping strobe: the comb fires next cycle with this sample included
  assign dec_wrap = stb && (dec_cnt_q >= reg_filtdec);

  always_comb begin
    case (reg_filtst)
      ST_S1:   x = cn1_q;
      ST_S2,
      ST_FAST: x = cn2_q;
      default: x = cn3_q;
    endcase
  end

  assign c1   = x - xdl_q;
  assign c2   = c1 - c1dl_q;
  assign c3   = c2 - c2dl1_q;
  assign fast = c2 + c2dl2_q;

  always_comb begin
    case (reg_filtst)
      ST_S1:   begin res = c1;   wu_need = 3'd1; end
      ST_S2:   begin res = c2;   wu_need = 3'd2; end
      ST_FAST: begin res = fast; wu_need = 3'd4; end
      default: begin res = c3;   wu_need = 3'd3; end
    endcase
  end

  assign shv = res >>> reg_filtsh;

  always_comb begin
    if (shv > SMAX)      sat = SMAX[OUT_W-1:0];
    else if (shv < SMIN) sat = SMIN[OUT_W-1:0];
    else                 sat = shv[OUT_W-1:0];
  end

  assign wu_done = (wu_cnt_q >= wu_need);
  assign accept  = comb_stb_q && wu_done;

  always_comb begin
    cn1_d      = cn1_q;
    cn2_d      = cn2_q;
    cn3_d      = cn3_q;
    xdl_d      = xdl_q;
    c1dl_d     = c1dl_q;
    c2dl1_d    = c2dl1_q;
    c2dl2_d    = c2dl2_q;
    dec_cnt_d  = dec_cnt_q;
    comb_stb_d = 1'b0;
    wu_cnt_d   = wu_cnt_q;
    dout_d     = dout_q;
    valid_d    = valid_q;
    upd_d      = 1'b0;
    ovr_d      = ovr_q;
    if (!reg_filten) begin
      cn1_d     = '0;
      cn2_d     = '0;
      cn3_d     = '0;
      xdl_d     = '0;
      c1dl_d    = '0;
      c2dl1_d   = '0;
      c2dl2_d   = '0;
      dec_cnt_d = '0;
      wu_cnt_d  = '0;
      dout_d    = '0;
      valid_d   = 1'b0;
      ovr_d     = 1'b0;
    end else begin
      if (stb) begin
        cn1_d     = cn1_q + inc;
        cn2_d     = cn2_q + cn1_q;
        cn3_d     = cn3_q + cn2_q;
        dec_cnt_d = dec_wrap ? '0 : dec_cnt_q + DEC_W'(1);
      end
      comb_stb_d = dec_wrap;
      if (comb_stb_q) begin
        xdl_d   = x;
        c1dl_d  = c1;
        c2dl1_d = c2;
        c2dl2_d = c2dl1_q;
        if (!wu_done) wu_cnt_d = wu_cnt_q + 3'd1;
      end
      if (accept) begin
        dout_d  = sat;
        upd_d   = 1'b1;
        valid_d = 1'b1;
        if (valid_q && !filt_data_ack) ovr_d = 1'b1;
      end else if (valid_q && filt_data_ack) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      cn1_q      <= '0;
      cn2_q      <= '0;
      cn3_q      <= '0;
      xdl_q      <= '0;
      c1dl_q     <= '0;
      c2dl1_q    <= '0;
      c2dl2_q    <= '0;
      dec_cnt_q  <= '0;
      comb_stb_q <= 1'b0;
      wu_cnt_q   <= '0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      upd_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      cn1_q      <= cn1_d;
      cn2_q      <= cn2_d;
      cn3_q      <= cn3_d;
      xdl_q      <= xdl_d;
      c1dl_q     <= c1dl_d;
      c2dl1_q    <= c2dl1_d;
      c2dl2_q    <= c2dl2_d;
      dec_cnt_q  <= dec_cnt_d;
      comb_stb_q <= comb_stb_d;
      wu_cnt_q   <= wu_cnt_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      upd_q      <= upd_d;
      ovr_q      <= ovr_d;
    end
  end

  assign filt_data_out    = dout_q;
  assign filt_data_valid  = valid_q;
  assign filt_data_update = upd_q;
  assign filt_overrun     = ovr_q;

endmodule
